// File: rtl/ntm_vector_function_sequencer_pkg.sv
// Shared math package: default widths, scalar operation codes and the
// vector sequencer state encoding.
package ntm_vector_function_sequencer_pkg;

  localparam int unsigned DATA_SIZE    = 64;
  localparam int unsigned CONTROL_SIZE = 4;

  localparam int unsigned OP_COSH          = 0;
  localparam int unsigned OP_SINH          = 1;
  localparam int unsigned OP_TANH          = 2;
  localparam int unsigned OP_EXPONENTIATOR = 3;
  localparam int unsigned OP_LOGARITHM     = 4;

  typedef enum logic [2:0] {
    STATE_IDLE,
    STATE_INPUT,
    STATE_ISSUE,
    STATE_WAIT,
    STATE_OUTPUT
  } state_t;

endpackage

// File: rtl/ntm_vector_function_sequencer.sv
// Vector function sequencer: streams a vector element by element through an
// external scalar function unit (cosh/sinh/tanh/exp/log), one operation in
// flight at a time, and strobes each result out in order.
module ntm_vector_function_sequencer #(
  parameter int unsigned DATA_SIZE    = ntm_vector_function_sequencer_pkg::DATA_SIZE,
  parameter int unsigned CONTROL_SIZE = ntm_vector_function_sequencer_pkg::CONTROL_SIZE
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    START,
  output logic                    READY,
  input  logic [CONTROL_SIZE-1:0] OPERATION,
  input  logic [DATA_SIZE-1:0]    SIZE_IN,
  input  logic                    DATA_IN_ENABLE,
  input  logic [DATA_SIZE-1:0]    DATA_IN,
  output logic                    DATA_ENABLE,
  output logic                    DATA_OUT_ENABLE,
  output logic [DATA_SIZE-1:0]    DATA_OUT,
  output logic                    ERROR,
  output logic                    FUNC_START,
  output logic [CONTROL_SIZE-1:0] FUNC_OPERATION,
  output logic [DATA_SIZE-1:0]    FUNC_DATA_IN,
  input  logic                    FUNC_READY,
  input  logic [DATA_SIZE-1:0]    FUNC_DATA_OUT
);

  import ntm_vector_function_sequencer_pkg::*;

  state_t                  state_q, state_d;
  logic [DATA_SIZE-1:0]    size_q, size_d;
  logic [DATA_SIZE-1:0]    idx_q, idx_d;
  logic [CONTROL_SIZE-1:0] op_q, op_d;
  logic [DATA_SIZE-1:0]    fdin_q, fdin_d;
  logic [DATA_SIZE-1:0]    dout_q, dout_d;
  logic                    err_q, err_d;
  logic                    zready_q, zready_d;

  logic op_valid;
  logic last_elem;

  // Codes above logarithm have no scalar implementation.
  assign op_valid  = (op_q <= CONTROL_SIZE'(OP_LOGARITHM));
  // size_q is never 0 outside IDLE, so size-1 cannot underflow here.
  assign last_elem = (idx_q == (size_q - DATA_SIZE'(1)));

  // State and datapath registers; reset abandons any vector in progress.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q  <= STATE_IDLE;
      size_q   <= '0;
      idx_q    <= '0;
      op_q     <= '0;
      fdin_q   <= '0;
      dout_q   <= '0;
      err_q    <= 1'b0;
      zready_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      size_q   <= size_d;
      idx_q    <= idx_d;
      op_q     <= op_d;
      fdin_q   <= fdin_d;
      dout_q   <= dout_d;
      err_q    <= err_d;
      zready_q <= zready_d;
    end
  end

  // Next-state and next-datapath logic for the element sequencing FSM.
  always_comb begin
    state_d  = state_q;
    size_d   = size_q;
    idx_d    = idx_q;
    op_d     = op_q;
    fdin_d   = fdin_q;
    dout_d   = dout_q;
    err_d    = err_q;
    zready_d = 1'b0;

    unique case (state_q)
      STATE_IDLE: begin
        if (START) begin
          err_d = 1'b0;
          if (SIZE_IN != '0) begin
            size_d  = SIZE_IN;
            op_d    = OPERATION;
            idx_d   = '0;
            state_d = STATE_INPUT;
          end else begin
            zready_d = 1'b1;
          end
        end
      end
      STATE_INPUT: begin
        if (DATA_IN_ENABLE) begin
          fdin_d  = DATA_IN;
          state_d = STATE_ISSUE;
        end
      end
      STATE_ISSUE: begin
        if (op_valid) begin
          state_d = STATE_WAIT;
        end else begin
          err_d   = 1'b1;
          dout_d  = '0;
          state_d = STATE_OUTPUT;
        end
      end
      STATE_WAIT: begin
        if (FUNC_READY) begin
          dout_d  = FUNC_DATA_OUT;
          state_d = STATE_OUTPUT;
        end
      end
      STATE_OUTPUT: begin
        if (last_elem) begin
          state_d = STATE_IDLE;
        end else begin
          idx_d   = idx_q + DATA_SIZE'(1);
          state_d = STATE_INPUT;
        end
      end
      default: state_d = STATE_IDLE;
    endcase
  end

  // Handshake outputs decoded from the registered state.
  always_comb begin
    DATA_ENABLE     = (state_q == STATE_INPUT);
    DATA_OUT_ENABLE = (state_q == STATE_OUTPUT);
    FUNC_START      = (state_q == STATE_ISSUE) && op_valid;
    READY           = ((state_q == STATE_OUTPUT) && last_elem) || zready_q;
  end

  assign FUNC_OPERATION = op_q;
  assign FUNC_DATA_IN   = fdin_q;
  assign DATA_OUT       = dout_q;
  assign ERROR          = err_q;

endmodule

// File: tb/tb_ntm_vector_function_sequencer.sv
// Self-checking bench for ntm_vector_function_sequencer: a latency-configurable
// scalar function unit model, a reference queue of expected results and a
// negedge monitor that checks handshakes, latency and result order.
module tb_ntm_vector_function_sequencer;

  logic        CLK;
  logic        RST;
  logic        START;
  logic        READY;
  logic [3:0]  OPERATION;
  logic [63:0] SIZE_IN;
  logic        DATA_IN_ENABLE;
  logic [63:0] DATA_IN;
  logic        DATA_ENABLE;
  logic        DATA_OUT_ENABLE;
  logic [63:0] DATA_OUT;
  logic        ERROR;
  logic        FUNC_START;
  logic [3:0]  FUNC_OPERATION;
  logic [63:0] FUNC_DATA_IN;
  logic        FUNC_READY;
  logic [63:0] FUNC_DATA_OUT;

  ntm_vector_function_sequencer #(
    .DATA_SIZE   (64),
    .CONTROL_SIZE(4)
  ) dut (
    .CLK            (CLK),
    .RST            (RST),
    .START          (START),
    .READY          (READY),
    .OPERATION      (OPERATION),
    .SIZE_IN        (SIZE_IN),
    .DATA_IN_ENABLE (DATA_IN_ENABLE),
    .DATA_IN        (DATA_IN),
    .DATA_ENABLE    (DATA_ENABLE),
    .DATA_OUT_ENABLE(DATA_OUT_ENABLE),
    .DATA_OUT       (DATA_OUT),
    .ERROR          (ERROR),
    .FUNC_START     (FUNC_START),
    .FUNC_OPERATION (FUNC_OPERATION),
    .FUNC_DATA_IN   (FUNC_DATA_IN),
    .FUNC_READY     (FUNC_READY),
    .FUNC_DATA_OUT  (FUNC_DATA_OUT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Stand-in scalar function: any distinct per-op mapping will do.
  function automatic logic [63:0] fu_f(input logic [3:0] op, input logic [63:0] x);
    return x * 64'd3 + {60'd0, op} + 64'h0123_4567_89AB_CDEF;
  endfunction

  // ---------------- scalar function unit model ----------------
  int          lat_cfg = 3;
  int          fu_cnt  = 0;
  logic [63:0] fu_x;
  logic [3:0]  fu_op;
  logic        model_ready = 1'b0;
  logic [63:0] model_data  = '0;
  logic        spur_ready  = 1'b0;

  assign FUNC_READY    = model_ready | spur_ready;
  assign FUNC_DATA_OUT = spur_ready ? 64'hDEAD_BEEF_DEAD_BEEF : model_data;

  always @(negedge CLK) begin
    if (FUNC_START) begin
      fu_x   = FUNC_DATA_IN;
      fu_op  = FUNC_OPERATION;
      fu_cnt = lat_cfg;
    end
  end

  always @(posedge CLK) begin
    #1;
    model_ready = 1'b0;
    if (fu_cnt > 0) begin
      fu_cnt--;
      if (fu_cnt == 0) begin
        model_ready = 1'b1;
        model_data  = fu_f(fu_op, fu_x);
      end
    end
  end

  // ---------------- reference queue and monitor ----------------
  logic [63:0] exp_arr [1024];
  int          wr = 0;            // written by stimulus only
  int          rd = 0;            // advanced by monitor only
  int          vec_size = 0;
  int          vec_op   = 0;
  logic [63:0] cur_x    = '0;
  int          s_base   = 0;

  int cyc = 0;
  always @(posedge CLK) cyc++;

  int fs_cnt = 0, strobe_cnt = 0, ready_cnt = 0, de_cnt = 0;
  int t_acc = 0, t_fr = 0;
  bit outstanding = 1'b0;

  always @(negedge CLK) begin
    if (!RST) begin
      outstanding = 1'b0;
      rd = wr;
    end else begin
      if (DATA_ENABLE) de_cnt++;
      if (DATA_ENABLE && DATA_IN_ENABLE) t_acc = cyc;
      if (FUNC_START) begin
        fs_cnt++;
        chk("one_outstanding", 64'(outstanding), 64'd0);
        chk("fs_latency", 64'(cyc), 64'(t_acc + 1));
        chk("func_op", 64'(FUNC_OPERATION), 64'(vec_op));
        chk("func_din", FUNC_DATA_IN, cur_x);
        outstanding = 1'b1;
      end
      if (FUNC_READY && outstanding) begin
        t_fr = cyc;
        outstanding = 1'b0;
      end
      if (DATA_OUT_ENABLE) begin
        strobe_cnt++;
        if (rd == wr) begin
          chk("strobe_unexpected", 64'd1, 64'd0);
        end else begin
          chk("dout", DATA_OUT, exp_arr[rd % 1024]);
          rd++;
        end
        if (vec_op <= 4) chk("out_latency", 64'(cyc), 64'(t_fr + 1));
        else             chk("out_latency_inv", 64'(cyc), 64'(t_acc + 2));
        chk("ready_at_last", 64'(READY), 64'((strobe_cnt - s_base) == vec_size));
      end
      if (READY) ready_cnt++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_de(output bit ok);
    int n = 0;
    while (!DATA_ENABLE && n < 100) begin
      tick();
      n++;
    end
    ok = DATA_ENABLE;
    if (!ok) chk("data_enable_timeout", 64'd0, 64'd1);
  endtask

  task automatic present(input logic [63:0] x);
    cur_x = x;
    exp_arr[wr % 1024] = (vec_op <= 4) ? fu_f(4'(vec_op), x) : 64'd0;
    wr++;
    DATA_IN_ENABLE = 1'b1;
    DATA_IN = x;
    tick();
    DATA_IN_ENABLE = 1'b0;
    DATA_IN = {$urandom, $urandom};
  endtask

  task automatic run_vec(input int size, input int op, input int lat, input int gap,
                         input bit inject, input bit seq_data);
    int fs0, de0, rdy0, n;
    bit ok;
    logic [63:0] x, last_exp;
    lat_cfg  = lat;
    vec_size = size;
    vec_op   = op;
    s_base   = strobe_cnt;
    fs0 = fs_cnt; de0 = de_cnt; rdy0 = ready_cnt;
    last_exp = '0;
    START = 1'b1; SIZE_IN = 64'(size); OPERATION = 4'(op);
    tick();
    START = 1'b0; SIZE_IN = 64'(size + 5); OPERATION = 4'(op + 1);
    for (int i = 0; i < size; i++) begin
      wait_de(ok);
      if (!ok) return;
      for (int g = 0; g < gap; g++) begin
        chk("de_held", 64'(DATA_ENABLE), 64'd1);
        chk("no_fs_while_starved", 64'(FUNC_START), 64'd0);
        spur_ready = inject && (g == 0);
        tick();
        spur_ready = 1'b0;
      end
      x = seq_data ? 64'(i) : {$urandom, $urandom};
      last_exp = (op <= 4) ? fu_f(4'(op), x) : 64'd0;
      present(x);
      if (inject && i == 0) begin
        tick();
        START = 1'b1; SIZE_IN = 64'd7; OPERATION = 4'd4;
        tick();
        START = 1'b0;
      end
    end
    n = 0;
    while ((strobe_cnt - s_base) < size && n < 200) begin
      tick();
      n++;
    end
    tick(); tick();
    chk("strobe_count", 64'(strobe_cnt - s_base), 64'(size));
    chk("fs_count", 64'(fs_cnt - fs0), (op <= 4) ? 64'(size) : 64'd0);
    chk("ready_count", 64'(ready_cnt - rdy0), 64'd1);
    chk("error_flag", 64'(ERROR), 64'(op > 4));
    chk("dout_hold", DATA_OUT, last_exp);
    chk("idle_no_de", 64'(DATA_ENABLE), 64'd0);
    if (de_cnt - de0 < size) chk("de_cycles", 64'(de_cnt - de0), 64'(size));
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout got=%0d exp=finish", cyc);
    $fatal(1);
  end

  initial begin
    int fs0, de0, rdy0, s0;
    bit ok;
    RST = 1'b0; START = 1'b0; OPERATION = '0; SIZE_IN = '0;
    DATA_IN_ENABLE = 1'b0; DATA_IN = '0;
    tick(); tick(); tick();
    chk("rst_ready", 64'(READY), 64'd0);
    chk("rst_de", 64'(DATA_ENABLE), 64'd0);
    chk("rst_doe", 64'(DATA_OUT_ENABLE), 64'd0);
    chk("rst_dout", DATA_OUT, 64'd0);
    chk("rst_error", 64'(ERROR), 64'd0);
    chk("rst_fs", 64'(FUNC_START), 64'd0);
    chk("rst_fop", 64'(FUNC_OPERATION), 64'd0);
    chk("rst_fdin", FUNC_DATA_IN, 64'd0);
    RST = 1'b1;
    tick();

    // Exponentiator over 0..3 with a 3-cycle unit.
    run_vec(4, 3, 3, 0, 1'b0, 1'b1);

    // Invalid code: zero results, sticky ERROR, no unit traffic.
    run_vec(2, 6, 3, 0, 1'b0, 1'b0);

    // Empty vector: READY next cycle, ERROR cleared, nothing requested.
    vec_size = 0; vec_op = 0; s_base = strobe_cnt;
    fs0 = fs_cnt; de0 = de_cnt; rdy0 = ready_cnt;
    START = 1'b1; SIZE_IN = 64'd0; OPERATION = 4'd0;
    tick();
    START = 1'b0;
    chk("zero_ready", 64'(READY), 64'd1);
    chk("zero_error_clr", 64'(ERROR), 64'd0);
    tick();
    chk("zero_ready_pulse", 64'(READY), 64'd0);
    tick(); tick();
    chk("zero_fs", 64'(fs_cnt - fs0), 64'd0);
    chk("zero_de", 64'(de_cnt - de0), 64'd0);
    chk("zero_ready_count", 64'(ready_cnt - rdy0), 64'd1);
    chk("zero_strobes", 64'(strobe_cnt - s_base), 64'd0);

    // START during WAIT and spurious FUNC_READY during INPUT are ignored.
    run_vec(3, 2, 3, 2, 1'b1, 1'b0);

    // Starved input for 10 cycles.
    run_vec(2, 0, 2, 10, 1'b0, 1'b0);

    // Reset while waiting on element 2 of 3.
    lat_cfg = 4; vec_size = 3; vec_op = 1; s_base = strobe_cnt;
    START = 1'b1; SIZE_IN = 64'd3; OPERATION = 4'd1;
    tick();
    START = 1'b0;
    wait_de(ok);
    if (ok) present({$urandom, $urandom});
    tick();
    wait_de(ok);
    if (ok) present({$urandom, $urandom});
    tick();
    #2;
    RST = 1'b0;
    #1;
    chk("arst_ready", 64'(READY), 64'd0);
    chk("arst_de", 64'(DATA_ENABLE), 64'd0);
    chk("arst_doe", 64'(DATA_OUT_ENABLE), 64'd0);
    chk("arst_dout", DATA_OUT, 64'd0);
    chk("arst_error", 64'(ERROR), 64'd0);
    chk("arst_fs", 64'(FUNC_START), 64'd0);
    chk("arst_fop", 64'(FUNC_OPERATION), 64'd0);
    chk("arst_fdin", FUNC_DATA_IN, 64'd0);
    s0 = strobe_cnt;
    tick(); tick();
    RST = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    chk("no_strobe_after_rst", 64'(strobe_cnt - s0), 64'd0);
    chk("dout_after_rst", DATA_OUT, 64'd0);
    chk("idle_after_rst", 64'(DATA_ENABLE), 64'd0);
    run_vec(3, 1, 2, 0, 1'b0, 1'b0);

    // Randomised vectors, including invalid codes.
    for (int v = 0; v < 10; v++) begin
      run_vec(int'($urandom_range(1, 5)), int'($urandom_range(0, 7)),
              int'($urandom_range(1, 4)), int'($urandom_range(0, 2)), 1'b0, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
